// File: rtl/fcore_loader_pkg.sv
// Shared types and constants for the fCore program loader: FSM states, error causes and ISA opcodes.
package fcore_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HEADER    = 3'd1,
    ST_INSTR     = 3'd2,
    ST_IMMEDIATE = 3'd3,
    ST_CHECKSUM  = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } loader_state_t;

  localparam int LOADER_ERR_W = 3;

  localparam logic [LOADER_ERR_W-1:0] ERR_NONE         = 3'd0;
  localparam logic [LOADER_ERR_W-1:0] ERR_BAD_OPCODE   = 3'd1;
  localparam logic [LOADER_ERR_W-1:0] ERR_LEN_ZERO     = 3'd2;
  localparam logic [LOADER_ERR_W-1:0] ERR_LEN_OVF      = 3'd3;
  localparam logic [LOADER_ERR_W-1:0] ERR_EARLY_LAST   = 3'd4;
  localparam logic [LOADER_ERR_W-1:0] ERR_MISSING_LAST = 3'd5;
  localparam logic [LOADER_ERR_W-1:0] ERR_NO_STOP      = 3'd6;
  localparam logic [LOADER_ERR_W-1:0] ERR_CHECKSUM     = 3'd7;

  // fCore ISA opcode map; ABS is the highest defined opcode.
  localparam int unsigned OP_NOP    = 0;
  localparam int unsigned OP_ADD    = 1;
  localparam int unsigned OP_SUB    = 2;
  localparam int unsigned OP_MUL    = 3;
  localparam int unsigned OP_ITF    = 4;
  localparam int unsigned OP_FTI    = 5;
  localparam int unsigned OP_LDC    = 6;
  localparam int unsigned OP_LDR    = 7;
  localparam int unsigned OP_BGT    = 8;
  localparam int unsigned OP_BLE    = 9;
  localparam int unsigned OP_BEQ    = 10;
  localparam int unsigned OP_BNE    = 11;
  localparam int unsigned OP_STOP   = 12;
  localparam int unsigned OP_AND    = 13;
  localparam int unsigned OP_OR     = 14;
  localparam int unsigned OP_NOT    = 15;
  localparam int unsigned OP_SATP   = 16;
  localparam int unsigned OP_SATN   = 17;
  localparam int unsigned OP_REC    = 18;
  localparam int unsigned OP_POPCNT = 19;
  localparam int unsigned OP_ABS    = 20;

endpackage

// File: rtl/fcore_opcode_classifier.sv
// Combinational decode of an fCore opcode into legality, immediate-follows and STOP flags.
module fcore_opcode_classifier
  import fcore_loader_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    legal,
  output logic                    has_immediate,
  output logic                    is_stop
);

  logic [31:0] op_ext;

  assign op_ext        = 32'(opcode);
  assign legal         = (op_ext <= OP_ABS);
  assign has_immediate = (op_ext == OP_LDC);
  assign is_stop       = (op_ext == OP_STOP);

endmodule

// File: rtl/fcore_program_loader.sv
// AXI-Stream program image loader for fCore instruction RAM with opcode validation.
// Optional trailing XOR checksum beat enabled by defining FCORE_LOADER_CHECKSUM_EN.
module fcore_program_loader
  import fcore_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   prog_data,
  input  logic                    prog_valid,
  input  logic                    prog_last,
  output logic                    prog_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_error,
  output logic [LOADER_ERR_W-1:0] error_code,
  output logic [ADDR_WIDTH:0]     prog_length,
  output loader_state_t           fsm_state
);

  // Handshake: a beat transfers on a clock edge where prog_valid and prog_ready are both high;
  // prog_ready depends only on the registered state, never on prog_valid.

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_t             state_q, state_n;
  logic                      draining_q, draining_n;
  logic [ADDR_WIDTH:0]       len_q, len_n;
  logic [ADDR_WIDTH:0]       cnt_q, cnt_n;
  logic                      done_q, done_n;
  logic                      err_q, err_n;
  logic [LOADER_ERR_W-1:0]   code_q, code_n;
  logic                      we_q, we_n;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_n;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_n;
`ifdef FCORE_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]     csum_q, csum_n;
`endif

  logic                      accept, is_final, fail, write_word;
  logic [LOADER_ERR_W-1:0]   fail_code;
  logic [ADDR_WIDTH:0]       hdr_len;
  logic                      op_legal, op_has_imm, op_is_stop;

  fcore_opcode_classifier #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_classifier (
    .opcode        (prog_data[OPCODE_WIDTH-1:0]),
    .legal         (op_legal),
    .has_immediate (op_has_imm),
    .is_stop       (op_is_stop)
  );

  assign prog_ready = (state_q == ST_HEADER) || (state_q == ST_INSTR) ||
                      (state_q == ST_IMMEDIATE) || (state_q == ST_CHECKSUM) ||
                      (state_q == ST_ERROR);
  assign busy       = (state_q == ST_HEADER) || (state_q == ST_INSTR) ||
                      (state_q == ST_IMMEDIATE) || (state_q == ST_CHECKSUM) ||
                      ((state_q == ST_ERROR) && draining_q);
  assign accept     = prog_valid && prog_ready;
  assign hdr_len    = prog_data[ADDR_WIDTH:0];
  // Word count reaching N-1 means the beat on the bus is program word N.
  assign is_final   = (cnt_q == (len_q - 1'b1));

  always_comb begin
    state_n    = state_q;
    draining_n = draining_q;
    len_n      = len_q;
    cnt_n      = cnt_q;
    done_n     = done_q;
    err_n      = err_q;
    code_n     = code_q;
    we_n       = 1'b0;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
`ifdef FCORE_LOADER_CHECKSUM_EN
    csum_n     = csum_q;
`endif
    fail       = 1'b0;
    fail_code  = ERR_NONE;
    write_word = 1'b0;

    if (start) begin
      state_n    = ST_HEADER;
      draining_n = 1'b0;
      len_n      = '0;
      cnt_n      = '0;
      done_n     = 1'b0;
      err_n      = 1'b0;
      code_n     = ERR_NONE;
      addr_n     = '0;
`ifdef FCORE_LOADER_CHECKSUM_EN
      csum_n     = '0;
`endif
    end else if (accept) begin
      case (state_q)
        ST_HEADER: begin
          if (hdr_len > MAX_LEN) begin
            fail = 1'b1; fail_code = ERR_LEN_OVF;
          end else if (hdr_len == '0) begin
            fail = 1'b1; fail_code = ERR_LEN_ZERO;
          end else if (prog_last) begin
            fail = 1'b1; fail_code = ERR_EARLY_LAST;
          end else begin
            len_n   = hdr_len;
            state_n = ST_INSTR;
          end
        end
        ST_INSTR: begin
          if (!op_legal) begin
            fail = 1'b1; fail_code = ERR_BAD_OPCODE;
          end else if (is_final) begin
            if (!op_is_stop) begin
              fail = 1'b1; fail_code = ERR_NO_STOP;
`ifdef FCORE_LOADER_CHECKSUM_EN
            end else if (prog_last) begin
              fail = 1'b1; fail_code = ERR_EARLY_LAST;
            end else begin
              write_word = 1'b1;
              state_n    = ST_CHECKSUM;
            end
`else
            end else if (!prog_last) begin
              fail = 1'b1; fail_code = ERR_MISSING_LAST;
            end else begin
              write_word = 1'b1;
              done_n     = 1'b1;
              state_n    = ST_DONE;
            end
`endif
          end else if (prog_last) begin
            fail = 1'b1; fail_code = ERR_EARLY_LAST;
          end else begin
            write_word = 1'b1;
            state_n    = op_has_imm ? ST_IMMEDIATE : ST_INSTR;
          end
        end
        ST_IMMEDIATE: begin
          // An immediate landing on word N leaves no room for the terminating STOP.
          if (is_final) begin
            fail = 1'b1; fail_code = ERR_NO_STOP;
          end else if (prog_last) begin
            fail = 1'b1; fail_code = ERR_EARLY_LAST;
          end else begin
            write_word = 1'b1;
            state_n    = ST_INSTR;
          end
        end
`ifdef FCORE_LOADER_CHECKSUM_EN
        ST_CHECKSUM: begin
          if (prog_data != csum_q) begin
            fail = 1'b1; fail_code = ERR_CHECKSUM;
          end else if (!prog_last) begin
            fail = 1'b1; fail_code = ERR_MISSING_LAST;
          end else begin
            done_n  = 1'b1;
            state_n = ST_DONE;
          end
        end
`endif
        ST_ERROR: begin
          if (draining_q && prog_last) draining_n = 1'b0;
        end
        default: ;
      endcase

      if (fail) begin
        state_n    = ST_ERROR;
        err_n      = 1'b1;
        code_n     = fail_code;
        draining_n = !prog_last;
      end

      if (write_word) begin
        we_n    = 1'b1;
        addr_n  = cnt_q[ADDR_WIDTH-1:0];
        wdata_n = prog_data;
        cnt_n   = cnt_q + 1'b1;
`ifdef FCORE_LOADER_CHECKSUM_EN
        csum_n  = csum_q ^ prog_data;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      draining_q <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef FCORE_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_n;
      draining_q <= draining_n;
      len_q      <= len_n;
      cnt_q      <= cnt_n;
      done_q     <= done_n;
      err_q      <= err_n;
      code_q     <= code_n;
      we_q       <= we_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
`ifdef FCORE_LOADER_CHECKSUM_EN
      csum_q     <= csum_n;
`endif
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign load_done   = done_q;
  assign load_error  = err_q;
  assign error_code  = code_q;
  assign prog_length = cnt_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fcore_program_loader.sv
// Directed bench for fcore_program_loader: write scoreboard plus status checks per image.
module tb_fcore_program_loader;
  import fcore_loader_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  localparam logic [DW-1:0] W_ADD  = 32'h0000_0121;  // opcode 1
  localparam logic [DW-1:0] W_SUB  = 32'h0000_0002;  // opcode 2
  localparam logic [DW-1:0] W_LDC  = 32'h0000_0046;  // opcode 6
  localparam logic [DW-1:0] W_STOP = 32'h0000_000C;  // opcode 12
  localparam logic [DW-1:0] W_NOP  = 32'h0000_0000;
  localparam logic [DW-1:0] W_BAD  = 32'h0000_0015;  // opcode 21
  localparam logic [DW-1:0] W_IMM  = 32'hDEAD_BEFF;  // low bits look like opcode 31

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic [DW-1:0]       prog_data;
  logic                prog_valid;
  logic                prog_last;
  logic                prog_ready;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                busy;
  logic                load_done;
  logic                load_error;
  logic [2:0]          error_code;
  logic [AW:0]         prog_length;
  loader_state_t       fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW+DW-1:0] exp_q[$];

  fcore_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OPCODE_WIDTH(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .prog_data   (prog_data),
    .prog_valid  (prog_valid),
    .prog_last   (prog_last),
    .prog_ready  (prog_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .load_done   (load_done),
    .load_error  (load_error),
    .error_code  (error_code),
    .prog_length (prog_length),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every RAM write must match the head of the expected queue
  always @(negedge clock) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
        check("write_data", 64'(mem_wdata), 64'(e[DW-1:0]));
      end
    end
  end

  // driver tasks
  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int guard;
    guard = 0;
    prog_data  = d;
    prog_valid = 1'b1;
    prog_last  = l;
    while (prog_ready !== 1'b1 && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 64'(prog_ready), 64'd1);
    @(posedge clock); #1;
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clock);
    #1;
    check("writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_error(input string tag, input logic [2:0] code);
    check({tag, "_error"}, 64'(load_error), 64'd1);
    check({tag, "_code"}, 64'(error_code), 64'(code));
    check({tag, "_done"}, 64'(load_done), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    prog_data = '0; prog_valid = 1'b0; prog_last = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 64'(prog_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_error", 64'(load_error), 64'd0);
    check("rst_code", 64'(error_code), 64'd0);
    check("rst_len", 64'(prog_length), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    reset = 1'b1;
    @(posedge clock); #1;
    check("idle_ready", 64'(prog_ready), 64'd0);

`ifdef FCORE_LOADER_CHECKSUM_EN
    // checksum good: 0x1 ^ 0xC = 0xD
    pulse_start();
    send_beat(32'd2, 1'b0);
    expect_write(12'd0, 32'h1); send_beat(32'h1, 1'b0);
    expect_write(12'd1, 32'hC); send_beat(32'hC, 1'b0);
    send_beat(32'hD, 1'b1);
    check("ck_done", 64'(load_done), 64'd1);
    check("ck_len", 64'(prog_length), 64'd2);
    settle();
    // checksum bad
    pulse_start();
    send_beat(32'd2, 1'b0);
    expect_write(12'd0, 32'h1); send_beat(32'h1, 1'b0);
    expect_write(12'd1, 32'hC); send_beat(32'hC, 1'b0);
    send_beat(32'hE, 1'b1);
    check_error("ck_bad", ERR_CHECKSUM);
    settle();
`else
    // successful 4-word image with LDC immediate
    pulse_start();
    check("arm_busy", 64'(busy), 64'd1);
    check("arm_ready", 64'(prog_ready), 64'd1);
    send_beat(32'd4, 1'b0);
    expect_write(12'd0, W_ADD);  send_beat(W_ADD, 1'b0);
    expect_write(12'd1, W_LDC);  send_beat(W_LDC, 1'b0);
    check("imm_state", 64'(fsm_state), 64'(ST_IMMEDIATE));
    expect_write(12'd2, W_IMM);  send_beat(W_IMM, 1'b0);
    expect_write(12'd3, W_STOP); send_beat(W_STOP, 1'b1);
    check("ok_done", 64'(load_done), 64'd1);
    check("ok_error", 64'(load_error), 64'd0);
    check("ok_busy", 64'(busy), 64'd0);
    check("ok_ready", 64'(prog_ready), 64'd0);
    check("ok_len", 64'(prog_length), 64'd4);
    settle();

    // bad opcode, drain to tlast, then ignore further beats
    pulse_start();
    send_beat(32'd2, 1'b0);
    send_beat(W_BAD, 1'b0);
    check_error("badop", ERR_BAD_OPCODE);
    check("badop_drain_busy", 64'(busy), 64'd1);
    check("badop_drain_ready", 64'(prog_ready), 64'd1);
    send_beat(W_STOP, 1'b1);
    check("badop_idle_busy", 64'(busy), 64'd0);
    check("badop_hold_ready", 64'(prog_ready), 64'd1);
    send_beat(W_ADD, 1'b1);
    check("badop_sticky_code", 64'(error_code), 64'(ERR_BAD_OPCODE));
    settle();

    // early last
    pulse_start();
    send_beat(32'd3, 1'b0);
    expect_write(12'd0, W_ADD); send_beat(W_ADD, 1'b0);
    send_beat(W_SUB, 1'b1);
    check_error("early", ERR_EARLY_LAST);
    check("early_len", 64'(prog_length), 64'd1);
    check("early_busy", 64'(busy), 64'd0);
    settle();

    // missing last on STOP, then drain
    pulse_start();
    send_beat(32'd2, 1'b0);
    expect_write(12'd0, W_ADD); send_beat(W_ADD, 1'b0);
    send_beat(W_STOP, 1'b0);
    check_error("nolast", ERR_MISSING_LAST);
    check("nolast_busy", 64'(busy), 64'd1);
    send_beat(W_NOP, 1'b1);
    check("nolast_drained", 64'(busy), 64'd0);
    settle();

    // LDC as final word: NO_STOP outranks EARLY_LAST
    pulse_start();
    send_beat(32'd2, 1'b0);
    expect_write(12'd0, W_ADD); send_beat(W_ADD, 1'b0);
    send_beat(W_LDC, 1'b1);
    check_error("nostop", ERR_NO_STOP);
    settle();

    // zero length
    pulse_start();
    send_beat(32'd0, 1'b0);
    check_error("lenzero", ERR_LEN_ZERO);
    settle();

    // length overflow (4097) and boundary length 4096 accepted
    pulse_start();
    send_beat(32'd4097, 1'b0);
    check_error("lenovf", ERR_LEN_OVF);
    pulse_start();
    check("restart_clears_error", 64'(load_error), 64'd0);
    send_beat(32'd4096, 1'b0);
    check("len_max_ok", 64'(load_error), 64'd0);
    check("len_max_state", 64'(fsm_state), 64'(ST_INSTR));
    settle();

    // abort after two writes; start coincident with a valid beat discards it
    pulse_start();
    send_beat(32'd4, 1'b0);
    expect_write(12'd0, W_ADD); send_beat(W_ADD, 1'b0);
    expect_write(12'd1, W_SUB); send_beat(W_SUB, 1'b0);
    start = 1'b1; prog_valid = 1'b1; prog_data = W_ADD;
    @(posedge clock); #1;
    start = 1'b0; prog_valid = 1'b0;
    check("abort_len", 64'(prog_length), 64'd0);
    check("abort_state", 64'(fsm_state), 64'(ST_HEADER));
    send_beat(32'd1, 1'b0);
    expect_write(12'd0, W_STOP); send_beat(W_STOP, 1'b1);
    check("reload_done", 64'(load_done), 64'd1);
    check("reload_len", 64'(prog_length), 64'd1);
    settle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
